// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into a DEPTH-entry FIFO that
// drains one entry per cycle into the register-file write port.
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [2:0]                 alu_reg,
    input  logic [15:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [2:0]                 mem_reg,
    input  logic [15:0]                mem_data,
    output logic                       mem_ready,
    output logic                       wr_en,
    output logic [2:0]                 wr_reg,
    output logic [15:0]                wr_data,
    output logic [7:0]                 pend_mask,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = 3;
    localparam int unsigned DW = 16;

    logic [RW-1:0] reg_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          fav_q, fav_d;       // 0 = ALU favoured, 1 = MEM favoured

    logic          pop;
    logic          full;
    logic          alu_acc, mem_acc, both_acc;
    logic          first_en, second_en;
    logic [RW-1:0] first_reg, second_reg;
    logic [DW-1:0] first_data, second_data;
    logic [7:0]    pend;

    // With a guaranteed pop whenever non-empty, only a full queue leaves a single free slot.
    assign pop       = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign alu_ready = !full || !mem_valid || !fav_q;
    assign mem_ready = !full || !alu_valid ||  fav_q;
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;
    assign both_acc  = alu_acc && mem_acc;

    // Enqueue ordering: favoured source lands first on a dual accept.
    always_comb begin
        first_en    = alu_acc || mem_acc;
        second_en   = both_acc;
        first_reg   = alu_reg;
        first_data  = alu_data;
        second_reg  = mem_reg;
        second_data = mem_data;
        if ((both_acc && fav_q) || (!alu_acc && mem_acc)) begin
            first_reg   = mem_reg;
            first_data  = mem_data;
            second_reg  = alu_reg;
            second_data = alu_data;
        end
    end

    always_comb begin
        count_d  = count_q + CW'(alu_acc) + CW'(mem_acc) - CW'(pop);
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(alu_acc) + PW'(mem_acc);
        fav_d    = (alu_valid && mem_valid) ? !fav_q : fav_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fav_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fav_q    <= fav_d;
        end
    end

    // Payload storage needs no reset: occupancy alone qualifies every read.
    always_ff @(posedge clk) begin
        if (first_en) begin
            reg_mem[wr_ptr_q]  <= first_reg;
            data_mem[wr_ptr_q] <= first_data;
        end
        if (second_en) begin
            reg_mem[wr_ptr_q + PW'(1)]  <= second_reg;
            data_mem[wr_ptr_q + PW'(1)] <= second_data;
        end
    end

    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pend[reg_mem[rd_ptr_q + PW'(i)]] = 1'b1;
            end
        end
    end

    assign wr_en     = pop;
    assign wr_reg    = pop ? reg_mem[rd_ptr_q]  : '0;
    assign wr_data   = pop ? data_mem[rd_ptr_q] : '0;
    assign pend_mask = pend;
    assign count     = count_q;

endmodule
